// File: rtl/outport_uart_tx_pkg.sv
// Shared definitions for the output-port UART transmitter: FSM encodings and frame geometry.
package outport_uart_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam int BITS_PER_BYTE  = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BITS_PER_BYTE * BYTES_PER_WORD;

endpackage

// File: rtl/outport_fifo.sv
// Word FIFO between the CPU output port and the UART shifter; registered level/full/empty.
module outport_fifo
    import outport_uart_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1,
    parameter int W     = WORD_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] level_nxt;

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + 1'b1;
        else if (pop && !push)
            level_nxt = level - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == CNT_W'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    // NOTE: storage is not reset; contents are only read behind the registered empty flag.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/outport_uart_tx.sv
// Output-port UART transmitter: queues 32-bit words and sends them 8N1, byte 0 first, LSB first.
module outport_uart_tx
    import outport_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    output logic              full,
    output logic [CNT_W-1:0]  level,
    output logic              busy,
    output logic              overflow,
    output logic              tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    state_t            state;
    logic [CW-1:0]     clk_cnt;
    logic [2:0]        bit_idx;
    logic [1:0]        byte_idx;
    logic [WORD_W-1:0] shift;
    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              bit_end;

    // A full FIFO still takes a write on the edge that frees a slot.
    assign pop     = (state == S_IDLE) && !fifo_empty;
    assign push    = wr_en && (!full || pop);
    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    outport_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W),
        .W     (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (wr_data),
        .dout    (fifo_dout),
        .full    (full),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_en && full && !pop)
                overflow <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift    <= fifo_dout;
                        state    <= S_START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= S_DATA;
                        tx      <= shift[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    // The word shifts right one bit per data bit, so the next byte lands in [7:0].
                    if (bit_end) begin
                        clk_cnt <= '0;
                        shift   <= shift >> 1;
                        if (bit_idx == 3'(BITS_PER_BYTE - 1)) begin
                            bit_idx <= '0;
                            state   <= S_STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (byte_idx == 2'(BYTES_PER_WORD - 1)) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= S_START;
                            tx       <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
